// File: rtl/pe_traffic_gen.sv
// Packet source/sink for one HNoC PE port: injects PKT_LIMIT LFSR-addressed packets
// into the switch and drains/counts everything the switch delivers back.
module pe_traffic_gen #(
    parameter int          ADDRESS    = 0,
    parameter int          NUM_PE     = 8,
    parameter int          ADDR_WIDTH = 3,
    parameter int          DATA_WIDTH = 32,
    parameter int          PKT_LIMIT  = 100,
    parameter int          GAP        = 0,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter bit          SELF_EN    = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic                             i_done,
    output logic [DATA_WIDTH+ADDR_WIDTH-1:0] o_data,
    output logic                             o_data_valid,
    input  logic                             i_data_ready,
    input  logic [DATA_WIDTH+ADDR_WIDTH-1:0] i_data,
    input  logic                             i_data_valid,
    output logic                             o_data_ready,
    output logic [31:0]                      o_sent_count,
    output logic [31:0]                      o_rcvd_count,
    output logic                             o_err,
    output logic                             o_tx_done,
    output logic [1:0]                       dbg_state
);

    localparam int PW    = DATA_WIDTH + ADDR_WIDTH;
    localparam int SEQ_W = DATA_WIDTH - ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [31:0]   gap_cnt;
    logic          tx_hs;
    logic          rx_hit;
    logic [31:0]   sent_next;
    logic [31:0]   rcvd_next;
    logic [15:0]   lfsr_next;
    logic          unused_rx_payload;

    // Handshake: a transfer happens on a posedge where valid and ready are both high;
    // the source never drops valid or changes data until that edge.
    assign tx_hs  = o_data_valid & i_data_ready;
    assign rx_hit = i_data_valid & o_data_ready;

    assign sent_next = (o_sent_count == '1) ? o_sent_count : o_sent_count + 32'd1;
    assign rcvd_next = (o_rcvd_count == '1) ? o_rcvd_count : o_rcvd_count + 32'd1;
    assign lfsr_next = lfsr_step(lfsr);
    assign dbg_state = state;

    // The sink only routes on the destination field; the payload is not inspected.
    assign unused_rx_payload = ^i_data[DATA_WIDTH-1:0];

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [PW-1:0] make_pkt(input logic [15:0] l, input logic [31:0] seq);
        logic [ADDR_WIDTH-1:0] self_addr;
        logic [ADDR_WIDTH-1:0] dest;
        self_addr = ADDR_WIDTH'(ADDRESS);
        dest      = l[ADDR_WIDTH-1:0];
        if (!SELF_EN && dest == self_addr)
            dest = ADDR_WIDTH'((ADDRESS + 1) % NUM_PE);
        make_pkt = {dest, self_addr, SEQ_W'(seq)};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            o_data_valid <= 1'b0;
            o_data       <= '0;
            o_sent_count <= '0;
            o_tx_done    <= 1'b0;
            lfsr         <= SEED;
            gap_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start && !i_done) begin
                        if (PKT_LIMIT == 0) begin
                            state     <= S_DONE;
                            o_tx_done <= 1'b1;
                        end else begin
                            state        <= S_SEND;
                            o_data_valid <= 1'b1;
                            o_data       <= make_pkt(lfsr, o_sent_count);
                        end
                    end
                end
                S_SEND: begin
                    if (tx_hs) begin
                        o_sent_count <= sent_next;
                        lfsr         <= lfsr_next;
                        // Next packet is staged now so back-to-back issue needs no bubble.
                        o_data       <= make_pkt(lfsr_next, sent_next);
                        if (sent_next == 32'(PKT_LIMIT) || i_done) begin
                            state        <= S_DONE;
                            o_data_valid <= 1'b0;
                            o_tx_done    <= 1'b1;
                        end else if (GAP != 0) begin
                            state        <= S_WAIT;
                            o_data_valid <= 1'b0;
                            gap_cnt      <= 32'(GAP);
                        end
                    end
                end
                S_WAIT: begin
                    if (i_done) begin
                        state     <= S_DONE;
                        o_tx_done <= 1'b1;
                    end else if (gap_cnt <= 32'd1) begin
                        state        <= S_SEND;
                        o_data_valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 32'd1;
                    end
                end
                default: begin
                    o_data_valid <= 1'b0;
                    o_tx_done    <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_data_ready <= 1'b0;
            o_rcvd_count <= '0;
            o_err        <= 1'b0;
        end else begin
            o_data_ready <= 1'b1;
            if (rx_hit) begin
                o_rcvd_count <= rcvd_next;
                if (i_data[PW-1 -: ADDR_WIDTH] != ADDR_WIDTH'(ADDRESS))
                    o_err <= 1'b1;
            end
        end
    end

endmodule
